receiver_uart_fsm: RTL and testbench

Serial-to-parallel UART receiver: 8 data bits, LSB first, one start bit (low) and one stop bit (high), no parity. It recovers bytes from an asynchronous, idle-high serial line by oversampling with the system clock. It pairs with the UART transmitter FSM in the protocols area, on the far end of the same line. It delivers each good byte with a one-cycle `valid` strobe and flags bad stop bits with a one-cycle `frame_err` strobe.

---
 rtl/receiver_uart_fsm.sv | 150 +++++++++++++++
 tb/tb_receiver_uart_fsm.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_uart_fsm.sv
// receiver_uart_fsm
//
// UART receiver: 8 data bits, LSB first, one low start bit, one high stop bit,
// no parity. It recovers bytes from an idle-high asynchronous line by
// oversampling with clk.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   rx         in   asynchronous serial line, idle high
//   dout       out  [7:0] last correctly framed byte, held between frames
//   valid      out  one-cycle strobe, dout is new and stable in that cycle
//   frame_err  out  one-cycle strobe, stop bit sampled low, byte discarded
//   busy       out  high whenever the FSM is not idle (decoded, no latency)
//   state_dbg  out  [1:0] current FSM state, for observation only
//
// Output protocol: there is no back-pressure. valid and frame_err are
// registered, mutually exclusive and high for exactly one cycle. dout only
// changes in the cycle valid is high and then holds until the next good frame.
//
// Parameter
//   CLKS_PER_BIT  clock cycles per serial bit period N (N >= 4).

module receiver_uart_fsm #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);

  // START validates at the middle of the start bit; DATA and STOP then sample
  // one full bit period later each, which lands in the middle of every bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          q1;
  logic          q2;
  logic          prev;
  logic          start_edge;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;

  // Two-flop synchronizer plus a history flop. All reset to the idle level,
  // so only a genuine high-to-low transition seen after reset starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1   <= 1'b1;
      q2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      q1   <= rx;
      q2   <= q1;
      prev <= q2;
    end
  end

  // Edge-qualified start: a line that is merely low (e.g. still low after a
  // framing error) never starts a frame; it has to go high and fall again.
  assign start_edge = !q2 && prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (start_edge) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            // Line back high at mid start bit: glitch, drop it silently.
            state <= q2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            // LSB arrives first, so shifting in from the top leaves bit 0
            // in sh[0] after the eighth sample.
            sh      <= {q2, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Leaving at mid stop bit gives half a bit of slack so a start
            // bit that immediately follows the stop bit is still caught.
            state <= IDLE;
            if (q2) begin
              dout  <= sh;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_receiver_uart_fsm.sv
// tb_receiver_uart_fsm
//
// Bench for receiver_uart_fsm with CLKS_PER_BIT = 16. A table of single
// frames (data, stop bit, transmitter bit period) with expected strobe kind,
// dout and latency; hand-written sequences for back-to-back frames, a framing
// error with the line held low, a short glitch and a reset mid-frame; and a
// randomized section. Every recorded stretch of line activity is replayed
// through a reference model that derives the strobes and the busy window
// from the frame timing rules directly on the sampled line history.
`timescale 1ns/1ps

module tb_receiver_uart_fsm;

  localparam int N    = 16;
  localparam int H    = N / 2;
  localparam int LAT  = H + 9 * N + 2;
  localparam int EW   = 42;
  localparam int HIST = 32768;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         period;
    logic [1:0] exp_kind;
    logic [7:0] exp_dout;
  } vec_t;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  receiver_uart_fsm #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int seg_from = 0;

  logic line_h   [HIST];
  logic busy_h   [HIST];
  logic exp_busy [HIST];

  // event word: {edge index[31:0], kind {frame_err, valid}, dout}
  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] tab_q[$];
  logic [EW-1:0] exp_q[$];
  logic [7:0]    model_dout = 8'h00;

  // Edge counter and line history: line_h[t] is rx as seen by rising edge t.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < HIST) line_h[cyc] = rx;
  end

  // Monitor, away from the active edge: busy_h[t] and events belong to the
  // cycle that follows rising edge t.
  always @(negedge clk) begin
    if (cyc < HIST) busy_h[cyc] = busy;
    if (valid || frame_err) begin
      obs_q.push_back(mk_ev(cyc, {frame_err, valid}, dout));
      tab_q.push_back(mk_ev(cyc, {frame_err, valid}, dout));
    end
  end

  function automatic logic [EW-1:0] mk_ev(input int t, input logic [1:0] kind,
                                          input logic [7:0] d);
    logic [31:0] tt;
    tt = t;
    return {tt, kind, d};
  endfunction

  function automatic int ev_edge(input logic [EW-1:0] ev);
    return int'(ev[41:10]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int period, output int k);
    k  = cyc + 1;
    rx = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (period) @(negedge clk);
    end
    rx = stop;
    repeat (period) @(negedge clk);
    rx = 1'b1;
  endtask

  // ---------------------------------------------------------------- reference model
  // Line as the receiver sees it in a stretch that begins at edge 'from'
  // (a reset edge or a quiet idle point): everything up to 'from' is idle.
  function automatic logic lv(input int j, input int from);
    if (j <= from || j >= HIST) return 1'b1;
    return line_h[j];
  endfunction

  // Frame rules: a frame begins at edge k when the line is sampled low at k
  // after being high at k-1, provided the receiver is idle again by edge k+1.
  // It is busy from k+2; the start bit is re-checked at k+H; data bit i is
  // taken at k+H+(i+1)*N and the stop bit at k+H+9*N; the strobe and the
  // return to idle both fall on edge k+2+H+9*N (k+2+H for a false start).
  task automatic check_range(input int from, input int to, input string tag);
    int            idle_from;
    int            fin;
    int            bad;
    int            n;
    logic [7:0]    b;
    logic          stp;
    logic [EW-1:0] ev;
    logic [EW-1:0] got_q[$];
    logic [EW-1:0] keep_q[$];

    exp_q.delete();
    for (int t = from + 1; t <= to; t++) exp_busy[t] = 1'b0;
    idle_from = from;
    for (int k = from + 1; k + 2 <= to; k++) begin
      if (k + 1 >= idle_from && lv(k, from) == 1'b0 && lv(k - 1, from) == 1'b1) begin
        if (lv(k + H, from) == 1'b1) fin = k + 2 + H;
        else                         fin = k + 2 + H + 9 * N;
        for (int t = k + 2; t < fin && t <= to; t++) exp_busy[t] = 1'b1;
        if (fin == k + 2 + H + 9 * N && fin <= to) begin
          for (int i = 0; i < 8; i++) b[i] = lv(k + H + (i + 1) * N, from);
          stp = lv(k + H + 9 * N, from);
          if (stp) begin
            model_dout = b;
            exp_q.push_back(mk_ev(fin, 2'b01, b));
          end else begin
            exp_q.push_back(mk_ev(fin, 2'b10, model_dout));
          end
        end
        idle_from = fin;
      end
    end

    while (obs_q.size() > 0) begin
      ev = obs_q.pop_front();
      if (ev_edge(ev) > from && ev_edge(ev) <= to) got_q.push_back(ev);
      else keep_q.push_back(ev);
    end
    obs_q = keep_q;

    check({tag, " model_event_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " model_event"}, got_q[i], exp_q[i]);

    bad = 0;
    for (int t = from + 1; t <= to; t++) if (busy_h[t] !== exp_busy[t]) bad++;
    check({tag, " busy_trace_mismatches"}, bad, 0);
  endtask

  task automatic checkpoint(input string tag);
    #1;
    check_range(seg_from, cyc, tag);
    seg_from = cyc;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #(300us);
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  // ---------------------------------------------------------------- test
  initial begin
    vec_t          vecs[8];
    int            k;
    int            k2;
    int            r;
    int            cnt;
    logic [EW-1:0] ev;
    logic [EW-1:0] ev1;
    logic          wave[10 * N];
    logic [7:0]    rbyte;
    logic          rstop;
    int            per;
    int            g;

    for (int i = 0; i < HIST; i++) begin
      line_h[i]   = 1'b1;
      busy_h[i]   = 1'b0;
      exp_busy[i] = 1'b0;
    end

    vecs[0] = '{8'hA5, 1'b1, 16, 2'b01, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 16, 2'b10, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 16, 2'b01, 8'h81};
    vecs[3] = '{8'hC3, 1'b1, 15, 2'b01, 8'hC3};
    vecs[4] = '{8'hC3, 1'b1, 17, 2'b01, 8'hC3};
    vecs[5] = '{8'h00, 1'b1, 16, 2'b01, 8'h00};
    vecs[6] = '{8'hFF, 1'b0, 16, 2'b10, 8'h00};
    vecs[7] = '{8'h5A, 1'b1, 16, 2'b01, 8'h5A};

    // reset
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    seg_from   = cyc;
    model_dout = 8'h00;
    rst = 1'b0;
    #1;
    check("reset dout", dout, 8'h00);
    check("reset valid", valid, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);

    // table of single frames
    for (int v = 0; v < 8; v++) begin
      idle(2 * N);
      tab_q.delete();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].period, k);
      idle(3 * N);
      check($sformatf("table[%0d] strobe_count", v), tab_q.size(), 1);
      ev = (tab_q.size() > 0) ? tab_q[0] : '0;
      check($sformatf("table[%0d] kind", v), ev[9:8], vecs[v].exp_kind);
      check($sformatf("table[%0d] dout", v), ev[7:0], vecs[v].exp_dout);
      check($sformatf("table[%0d] latency", v), ev_edge(ev) - k, LAT);
    end
    checkpoint("table");

    // back-to-back 0x00 then 0xFF with no idle gap
    idle(2 * N);
    tab_q.delete();
    send_frame(8'h00, 1'b1, N, k);
    send_frame(8'hFF, 1'b1, N, k2);
    idle(3 * N);
    check("b2b strobe_count", tab_q.size(), 2);
    ev  = (tab_q.size() > 0) ? tab_q[0] : '0;
    ev1 = (tab_q.size() > 1) ? tab_q[1] : '0;
    check("b2b first", {ev[9:8], ev[7:0]}, {2'b01, 8'h00});
    check("b2b second", {ev1[9:8], ev1[7:0]}, {2'b01, 8'hFF});
    check("b2b first latency", ev_edge(ev) - k, LAT);
    check("b2b spacing", ev_edge(ev1) - ev_edge(ev), 10 * N);
    checkpoint("b2b");

    // framing error, line then held low, then released and a clean 0x81
    idle(2 * N);
    tab_q.delete();
    send_frame(8'h3C, 1'b0, N, k);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    check("ferr strobe_count", tab_q.size(), 1);
    ev = (tab_q.size() > 0) ? tab_q[0] : '0;
    check("ferr event", {ev[9:8], ev[7:0]}, {2'b10, 8'hFF});
    check("ferr latency", ev_edge(ev) - k, LAT);
    cnt = 0;
    for (int t = k + LAT; t <= cyc; t++) if (busy_h[t] !== 1'b0) cnt++;
    check("ferr hold_low busy_cycles", cnt, 0);
    check("ferr hold_low dout", dout, 8'hFF);
    idle(2 * N);
    tab_q.delete();
    send_frame(8'h81, 1'b1, N, k);
    idle(3 * N);
    check("after_ferr strobe_count", tab_q.size(), 1);
    ev = (tab_q.size() > 0) ? tab_q[0] : '0;
    check("after_ferr event", {ev[9:8], ev[7:0]}, {2'b01, 8'h81});
    checkpoint("ferr");

    // 3-cycle glitch while idle
    idle(2 * N);
    tab_q.delete();
    k  = cyc + 1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(4 * N);
    #1;
    cnt = 0;
    for (int t = k; t <= cyc; t++) if (busy_h[t] === 1'b1) cnt++;
    check("glitch busy_cycles", cnt, H);
    check("glitch busy_rise", {busy_h[k + 1], busy_h[k + 2]}, 2'b01);
    check("glitch busy_fall", busy_h[k + 2 + H], 1'b0);
    check("glitch strobe_count", tab_q.size(), 0);
    check("glitch dout", dout, 8'h81);
    checkpoint("glitch");

    // reset for one cycle during data bit 4 of a 0x5A frame
    idle(2 * N);
    rbyte = 8'h5A;
    for (int c = 0; c < 10 * N; c++) begin
      if (c < N)            wave[c] = 1'b0;
      else if (c < 9 * N)   wave[c] = rbyte[c / N - 1];
      else                  wave[c] = 1'b1;
    end
    r = 0;
    for (int c = 0; c < 10 * N; c++) begin
      rx = wave[c];
      if (c == 5 * N + 4) rst = 1'b1;
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        r   = cyc;
        #1;
        check("midreset dout", dout, 8'h00);
        check("midreset valid", valid, 1'b0);
        check("midreset frame_err", frame_err, 1'b0);
        check("midreset busy", busy, 1'b0);
        check_range(seg_from, r - 1, "pre_reset");
        seg_from   = r;
        model_dout = 8'h00;
      end
    end
    idle(12 * N);
    tab_q.delete();
    send_frame(8'h5A, 1'b1, N, k);
    idle(3 * N);
    check("post_reset strobe_count", tab_q.size(), 1);
    ev = (tab_q.size() > 0) ? tab_q[0] : '0;
    check("post_reset event", {ev[9:8], ev[7:0]}, {2'b01, 8'h5A});
    check("post_reset latency", ev_edge(ev) - k, LAT);
    checkpoint("reset");

    // randomized frames, bad stop bits, rate skew and glitches
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        g  = int'($urandom_range(1, 12));
        rx = 1'b0;
        repeat (g) @(negedge clk);
        idle(int'($urandom_range(1, 40)));
      end else begin
        rbyte = 8'($urandom_range(0, 255));
        rstop = ($urandom_range(0, 4) != 0);
        per   = int'($urandom_range(15, 17));
        send_frame(rbyte, rstop, per, k);
        idle(int'($urandom_range(0, 30)));
      end
    end
    idle(12 * N);
    checkpoint("random");

    check("stray_events", obs_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
